// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
package disp_pkg;
    localparam int         NUM_DIGITS = 4;
    localparam logic [7:0] SSEG_OFF   = 8'hFF;
    localparam logic [3:0] AN_OFF     = 4'hF;
endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex-to-7-segment decoder, active-low outputs: [7]=dp, [6:0]=a..g (a at bit 6).
module hex_to_sseg (
    input  logic [3:0] hex,
    input  logic       dp_n,
    output logic [7:0] sseg
);
    always_comb begin
        sseg[7] = dp_n;
        case (hex)
            4'h0: sseg[6:0] = 7'b0000001;
            4'h1: sseg[6:0] = 7'b1001111;
            4'h2: sseg[6:0] = 7'b0010010;
            4'h3: sseg[6:0] = 7'b0000110;
            4'h4: sseg[6:0] = 7'b1001100;
            4'h5: sseg[6:0] = 7'b0100100;
            4'h6: sseg[6:0] = 7'b0100000;
            4'h7: sseg[6:0] = 7'b0001111;
            4'h8: sseg[6:0] = 7'b0000000;
            4'h9: sseg[6:0] = 7'b0000100;
            4'hA: sseg[6:0] = 7'b0001000;
            4'hB: sseg[6:0] = 7'b1100000;
            4'hC: sseg[6:0] = 7'b0110001;
            4'hD: sseg[6:0] = 7'b1000010;
            4'hE: sseg[6:0] = 7'b0110000;
            default: sseg[6:0] = 7'b0111000;
        endcase
    end
endmodule

// File: rtl/disp_hex_mux.sv
// Time-multiplexed 4-digit common-anode display driver with frame-synchronous
// double-buffered digit data and per-slot anti-ghost dead time.
module disp_hex_mux
    import disp_pkg::*;
#(
    parameter int N         = 18,
    parameter int BLANK_CYC = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);
    localparam logic [N-3:0] BLANK_LIM = BLANK_CYC[N-3:0];

    logic [N-1:0]              cnt;
    logic                      wrap;
    logic [1:0]                sel;
    logic [N-3:0]              off;

    logic                      pend_vld;
    logic [4*NUM_DIGITS-1:0]   pend_hex;
    logic [NUM_DIGITS-1:0]     pend_dp;
    logic [NUM_DIGITS-1:0]     pend_blank;

    logic [4*NUM_DIGITS-1:0]   sh_hex;
    logic [NUM_DIGITS-1:0]     sh_dp;
    logic [NUM_DIGITS-1:0]     sh_blank;

    logic [3:0]                nib_p0;
    logic                      dp_n_p0;
    logic                      dark_p0;
    logic [7:0]                dec_p0;
    logic [NUM_DIGITS-1:0]     an_p0;
    logic [7:0]                sseg_p0;

    assign wrap = &cnt;
    assign sel  = cnt[N-1:N-2];
    assign off  = cnt[N-3:0];

    // Scan counter and the pending/shadow buffers; shadow only moves at the frame wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            pend_vld   <= 1'b0;
            pend_hex   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            sh_hex     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
        end else begin
            cnt <= cnt + N'(1);
            if (load) begin
                pend_hex   <= hex_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            if (wrap && load) begin
                // Bypass pending so a load landing on the wrap is shown in the very next frame.
                sh_hex   <= hex_in;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
                pend_vld <= 1'b0;
            end else if (wrap && pend_vld) begin
                sh_hex   <= pend_hex;
                sh_dp    <= pend_dp;
                sh_blank <= pend_blank;
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_vld <= 1'b1;
            end
        end
    end

    // Stage p0: digit mux, decode and dead-time gating from the current count.
    always_comb begin
        nib_p0  = sh_hex[{sel, 2'b00} +: 4];
        dp_n_p0 = ~sh_dp[sel];
        dark_p0 = (off < BLANK_LIM) || sh_blank[sel];
        an_p0   = dark_p0 ? AN_OFF : ~(4'b0001 << sel);
        sseg_p0 = dark_p0 ? SSEG_OFF : dec_p0;
    end

    hex_to_sseg u_dec (
        .hex  (nib_p0),
        .dp_n (dp_n_p0),
        .sseg (dec_p0)
    );

    // Stage p1: registered outputs, one cycle behind cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= AN_OFF;
            sseg       <= SSEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_p0;
            sseg       <= sseg_p0;
            frame_tick <= wrap;
        end
    end
endmodule

// File: tb/tb_disp_hex_mux.sv
// Randomized + directed bench for disp_hex_mux (N=4, BLANK_CYC=1) against a frame-level model.
module tb_disp_hex_mux;
    localparam int N     = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 16;
    localparam int SLOT  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: position within frame, shown digits, pending digits
    int m_pos = 0;
    int sh_hex[4], sh_dp[4], sh_bl[4];
    int pd_hex[4], pd_dp[4], pd_bl[4];
    bit m_pv = 0;
    logic [3:0] exp_an;
    logic [7:0] exp_sseg;
    logic       exp_ft;

    disp_hex_mux #(.N(N), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // lit segments per hex value, spelled out by segment letter
    function automatic logic [6:0] lit_mask(input int v);
        string s;
        logic [6:0] m;
        case (v)
            0: s = "abcdef";   1: s = "bc";      2: s = "abdeg";   3: s = "abcdg";
            4: s = "bcfg";     5: s = "acdfg";   6: s = "acdefg";  7: s = "abc";
            8: s = "abcdefg";  9: s = "abcdfg";  10: s = "abcefg"; 11: s = "cdefg";
            12: s = "adef";    13: s = "bcdeg";  14: s = "adefg";  default: s = "aefg";
        endcase
        m = '0;
        for (int i = 0; i < s.len(); i++) m[6 - (s[i] - "a")] = 1'b1;
        return m;
    endfunction

    function automatic void model_edge(input bit r, input bit ld, input logic [15:0] h,
                                       input logic [3:0] d, input logic [3:0] b);
        int dig, o;
        if (r) begin
            exp_an = 4'hF; exp_sseg = 8'hFF; exp_ft = 1'b0;
            m_pos = 0; m_pv = 0;
            for (int i = 0; i < 4; i++) begin
                sh_hex[i] = 0; sh_dp[i] = 0; sh_bl[i] = 0;
                pd_hex[i] = 0; pd_dp[i] = 0; pd_bl[i] = 0;
            end
            return;
        end
        dig = m_pos / SLOT;
        o   = m_pos % SLOT;
        if (o < BLANK || sh_bl[dig] != 0) begin
            exp_an = 4'hF; exp_sseg = 8'hFF;
        end else begin
            exp_an   = 4'(15 - (1 << dig));
            exp_sseg = {(sh_dp[dig] == 0), ~lit_mask(sh_hex[dig])};
        end
        exp_ft = (m_pos == FRAME - 1);
        if (m_pos == FRAME - 1 && (ld || m_pv)) begin
            for (int i = 0; i < 4; i++) begin
                if (ld) begin
                    sh_hex[i] = int'((h >> (4 * i)) & 16'hF);
                    sh_dp[i] = int'(d[i]); sh_bl[i] = int'(b[i]);
                end else begin
                    sh_hex[i] = pd_hex[i]; sh_dp[i] = pd_dp[i]; sh_bl[i] = pd_bl[i];
                end
            end
            m_pv = 0;
        end else if (ld) begin
            for (int i = 0; i < 4; i++) begin
                pd_hex[i] = int'((h >> (4 * i)) & 16'hF);
                pd_dp[i] = int'(d[i]); pd_bl[i] = int'(b[i]);
            end
            m_pv = 1;
        end
        m_pos = (m_pos + 1) % FRAME;
    endfunction

    task automatic cyc(input bit r, input bit ld, input logic [15:0] h,
                       input logic [3:0] d, input logic [3:0] b);
        @(negedge clk);
        reset = r; load = ld; hex_in = h; dp_in = d; blank_in = b;
        @(posedge clk);
        model_edge(r, ld, h, d, b);
        #1;
        chk("an", {4'h0, an}, {4'h0, exp_an});
        chk("sseg", sseg, exp_sseg);
        chk("frame_tick", {7'h0, frame_tick}, {7'h0, exp_ft});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_to(input int pos);
        for (int i = 0; i < FRAME && m_pos != pos; i++) cyc(0, 0, 16'h0, 4'h0, 4'h0);
    endtask

    int seen_a;

    initial begin
        // reset held, then free-run showing zeros
        for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0, 4'h0, 4'h0);
        chk("reset_an_const", {4'h0, an}, 8'h0F);
        chk("reset_sseg_const", sseg, 8'hFF);
        idle(20);

        // mid-frame load, shown only from the next frame
        idle_to(5);
        cyc(0, 1, 16'h1234, 4'b0001, 4'b0000);
        idle_to(0);
        idle(2);
        chk("digit0_4dp_const", sseg, 8'h4C);
        idle(36);

        // last write wins within a frame
        idle_to(2);
        cyc(0, 1, 16'hAAAA, 4'h0, 4'h0);
        idle_to(8);
        cyc(0, 1, 16'h5555, 4'h0, 4'h0);
        seen_a = 0;
        for (int i = 0; i < 36; i++) begin
            idle(1);
            if (sseg == 8'h88) seen_a++;
        end
        chk("no_digit_A", 8'(seen_a), 8'h0);

        // load coinciding with the wrap commits directly
        idle_to(FRAME - 1);
        cyc(0, 1, 16'h00E0, 4'h0, 4'h0);
        idle(36);

        // blanked digits 1 and 3
        idle_to(3);
        cyc(0, 1, 16'h9876, 4'b1111, 4'b1010);
        idle(40);

        // reset mid-frame discards pending load
        idle_to(6);
        cyc(0, 1, 16'hFEDC, 4'b0101, 4'h0);
        idle_to(9);
        cyc(1, 0, 16'h0, 4'h0, 4'h0);
        idle(40);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
